// File: rtl/repeat_sum.sv
// Repeated-block ID sum engine: sums every D-digit x <= n whose decimal string is a
// block repeated REPS times (REPS = 0: any count >= 2, via inclusion-exclusion over primes of D).
module repeat_sum #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SUM_WIDTH  = 128,
  parameter int unsigned MAX_DIGITS = 19,
  parameter int unsigned REPS       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] n_in,
  input  logic [4:0]            n_digs_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_WIDTH-1:0]  sum_out,
  output logic                  err_out
);

  typedef enum logic [1:0] {IDLE, SETUP, TERM, DONE} state_t;

  localparam int unsigned REPS_DIV = (REPS == 0) ? 1 : REPS;

  function automatic logic [DATA_WIDTH-1:0] pow10_const(input int unsigned k);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'(1);
    for (int unsigned i = 0; i < k; i++) r = r * DATA_WIDTH'(10);
    return r;
  endfunction

  function automatic logic is_prime(input int unsigned v);
    case (v)
      2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] pow10_tbl [0:MAX_DIGITS];
  for (genvar g = 0; g <= MAX_DIGITS; g++) begin : g_pow10
    assign pow10_tbl[g] = pow10_const(g);
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] n_q, base_q, lb_q, ub_q, cnt_q;
  logic [DATA_WIDTH:0]   s_q;
  logic [4:0]            d_q;
  logic [SUM_WIDTH-1:0]  acc_q;
  logic                  err_q;
  logic [1:0]            t_cnt_q, t_idx_q, phase_q;
  logic [4:0]            term_b_q [0:2];
  logic [2:0]            term_neg_q;

  // Term list construction from the latched digit count
  int unsigned           dd, q1, q2, nprimes;
  logic [1:0]            set_cnt;
  logic [4:0]            set_b [0:2];
  logic [2:0]            set_neg;
  logic                  set_err;

  always_comb begin
    dd      = 32'(d_q);
    nprimes = 0;
    q1      = 1;
    q2      = 1;
    set_cnt = '0;
    set_err = 1'b0;
    set_neg = '0;
    for (int unsigned i = 0; i < 3; i++) set_b[i] = '0;
    for (int unsigned p = 2; p < 32; p++) begin
      if (is_prime(p) && (dd % p == 0)) begin
        if (nprimes == 0)      q1 = p;
        else if (nprimes == 1) q2 = p;
        nprimes = nprimes + 1;
      end
    end
    if (dd == 0 || dd > MAX_DIGITS) begin
      set_err = 1'b1;
    end else if (REPS != 0) begin
      if (dd >= REPS && (dd % REPS_DIV) == 0) begin
        set_cnt  = 2'd1;
        set_b[0] = 5'(dd / REPS_DIV);
      end
    end else if (nprimes >= 2) begin
      // Positive terms first so the unsigned accumulator never underflows
      set_cnt    = 2'd3;
      set_b[0]   = 5'(dd / q1);
      set_b[1]   = 5'(dd / q2);
      set_b[2]   = 5'(dd / (q1 * q2));
      set_neg[2] = 1'b1;
    end else if (nprimes == 1 && dd > 1) begin
      set_cnt  = 2'd1;
      set_b[0] = 5'(dd / q1);
    end
  end

  // Per-term datapath; one shared divider: P0 base, P1 n/base
  logic [4:0]            cur_b;
  logic [DATA_WIDTH-1:0] blk_max, div_num, div_den, div_q, lb_calc, ub_calc;
  logic [SUM_WIDTH-1:0]  prod, term;

  assign cur_b   = term_b_q[t_idx_q];
  assign blk_max = pow10_tbl[cur_b] - DATA_WIDTH'(1);
  assign div_num = (phase_q == 2'd0) ? (pow10_tbl[d_q] - DATA_WIDTH'(1)) : n_q;
  assign div_den = (phase_q == 2'd0) ? blk_max : base_q;
  assign div_q   = div_num / div_den;
  assign lb_calc = pow10_tbl[cur_b - 5'd1];
  assign ub_calc = (div_q < blk_max) ? div_q : blk_max;
  assign prod    = SUM_WIDTH'(s_q) * SUM_WIDTH'(cnt_q);
  assign term    = SUM_WIDTH'(base_q) * (prod >> 1);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum_out   = '0;
    err_out   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SETUP;
      end
      SETUP: state_d = (set_cnt == 2'd0) ? DONE : TERM;
      TERM: begin
        if (phase_q == 2'd3 && t_idx_q == t_cnt_q - 2'd1) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        sum_out   = acc_q;
        err_out   = err_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      n_q        <= '0;
      d_q        <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      t_cnt_q    <= '0;
      t_idx_q    <= '0;
      phase_q    <= '0;
      base_q     <= '0;
      lb_q       <= '0;
      ub_q       <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      term_b_q   <= '{default: '0};
      term_neg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            n_q   <= n_in;
            d_q   <= n_digs_in;
            acc_q <= '0;
            err_q <= 1'b0;
          end
        end
        SETUP: begin
          term_b_q   <= set_b;
          term_neg_q <= set_neg;
          t_cnt_q    <= set_cnt;
          err_q      <= set_err;
          t_idx_q    <= '0;
          phase_q    <= '0;
        end
        TERM: begin
          phase_q <= phase_q + 2'd1;
          case (phase_q)
            2'd0: base_q <= div_q;
            2'd1: begin
              lb_q <= lb_calc;
              ub_q <= ub_calc;
            end
            2'd2: begin
              // Empty range forces a zero term through the product
              if (ub_q < lb_q) begin
                s_q   <= '0;
                cnt_q <= '0;
              end else begin
                s_q   <= {1'b0, lb_q} + {1'b0, ub_q};
                cnt_q <= ub_q - lb_q + DATA_WIDTH'(1);
              end
            end
            default: begin
              acc_q   <= term_neg_q[t_idx_q] ? (acc_q - term) : (acc_q + term);
              t_idx_q <= t_idx_q + 2'd1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_repeat_sum.sv
// Directed bench for repeat_sum: one exact-mode (REPS=2) and one any-mode (REPS=0) instance
// sharing clock, reset, operand bus and out_ready.
module tb_repeat_sum;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         iv2, iv0, ir2, ir0, ov2, ov0, er2, er0, out_ready;
  logic [63:0]  n_in;
  logic [4:0]   n_digs_in;
  logic [127:0] s2, s0;

  int n_cmp = 0;
  int n_bad = 0;

  repeat_sum #(.DATA_WIDTH(64), .SUM_WIDTH(128), .MAX_DIGITS(19), .REPS(2)) dut_exact (
    .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(ir2), .n_in(n_in),
    .n_digs_in(n_digs_in), .out_valid(ov2), .out_ready(out_ready), .sum_out(s2), .err_out(er2)
  );

  repeat_sum #(.DATA_WIDTH(64), .SUM_WIDTH(128), .MAX_DIGITS(19), .REPS(0)) dut_any (
    .clock(clock), .reset(reset), .in_valid(iv0), .in_ready(ir0), .n_in(n_in),
    .n_digs_in(n_digs_in), .out_valid(ov0), .out_ready(out_ready), .sum_out(s0), .err_out(er0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit any);
    check($sformatf("%s/in_ready", tag), 128'(any ? ir0 : ir2), 128'd1);
    check($sformatf("%s/out_valid", tag), 128'(any ? ov0 : ov2), 128'd0);
    check($sformatf("%s/sum", tag), any ? s0 : s2, 128'd0);
    check($sformatf("%s/err", tag), 128'(any ? er0 : er2), 128'd0);
  endtask

  task automatic run_req(input string name, input bit any, input logic [4:0] d,
                         input logic [63:0] n, input logic [127:0] exp_sum,
                         input logic exp_err, input int exp_lat, input int hold);
    int lat;
    @(negedge clock);
    n_in      = n;
    n_digs_in = d;
    if (any) iv0 = 1'b1;
    else     iv2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iv0 = 1'b0;
    iv2 = 1'b0;
    check($sformatf("%s/busy", name), 128'(any ? ir0 : ir2), 128'd0);
    lat = 1;
    while (!(any ? ov0 : ov2) && lat < 40) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    check($sformatf("%s/latency", name), 128'(lat), 128'(exp_lat));
    for (int i = 0; i <= hold; i++) begin
      check($sformatf("%s/valid%0d", name, i), 128'(any ? ov0 : ov2), 128'd1);
      check($sformatf("%s/sum%0d", name, i), any ? s0 : s2, exp_sum);
      check($sformatf("%s/err%0d", name, i), 128'(any ? er0 : er2), 128'(exp_err));
      check($sformatf("%s/ready%0d", name, i), 128'(any ? ir0 : ir2), 128'd0);
      if (i < hold) begin
        @(posedge clock);
        @(negedge clock);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check($sformatf("%s/idle_after", name), 128'(any ? ir0 : ir2), 128'd1);
    check($sformatf("%s/drop_valid", name), 128'(any ? ov0 : ov2), 128'd0);
  endtask

  initial begin
    reset     = 1'b0;
    iv0       = 1'b0;
    iv2       = 1'b0;
    out_ready = 1'b0;
    n_in      = '0;
    n_digs_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("rst_exact", 1'b0);
    check_idle("rst_any", 1'b1);
    reset = 1'b1;

    // name, any, D, n, sum, err, latency, extra hold cycles
    run_req("x_d2",      1'b0, 5'd2,  64'd99,      128'd495,       1'b0, 6, 0);
    run_req("x_d4_bp",   1'b0, 5'd4,  64'd1234,    128'd3333,      1'b0, 6, 10);
    run_req("x_d3",      1'b0, 5'd3,  64'd999,     128'd0,         1'b0, 2, 0);
    run_req("x_d2_big",  1'b0, 5'd2,  64'd1000,    128'd495,       1'b0, 6, 0);
    run_req("x_d4_low",  1'b0, 5'd4,  64'd999,     128'd0,         1'b0, 6, 0);
    run_req("x_d6",      1'b0, 5'd6,  64'd999999,  128'd495044550, 1'b0, 6, 0);
    run_req("x_d20",     1'b0, 5'd20, 64'd5,       128'd0,         1'b1, 2, 0);
    run_req("a_d1",      1'b1, 5'd1,  64'd9,       128'd0,         1'b0, 2, 0);
    run_req("a_d6",      1'b1, 5'd6,  64'd999999,  128'd539589960, 1'b0, 14, 0);
    run_req("a_d0",      1'b1, 5'd0,  64'd50,      128'd0,         1'b1, 2, 0);
    run_req("a_d4_low",  1'b1, 5'd4,  64'd999,     128'd0,         1'b0, 6, 0);
    run_req("a_d4",      1'b1, 5'd4,  64'd9999,    128'd495405,    1'b0, 6, 0);
    run_req("a_d19",     1'b1, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF,
            128'd49999999999999999995, 1'b0, 6, 0);

    // Reset while the any-mode engine is mid-TERM
    @(negedge clock);
    n_in      = 64'd999999;
    n_digs_in = 5'd6;
    iv0       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iv0 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("midterm/busy", 128'(ir0), 128'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_idle("midterm_rst", 1'b1);
    reset = 1'b1;
    run_req("a_d6_again", 1'b1, 5'd6, 64'd999999, 128'd539589960, 1'b0, 14, 0);

    // Reset and in_valid together: request must not be taken
    @(negedge clock);
    reset     = 1'b0;
    n_in      = 64'd99;
    n_digs_in = 5'd2;
    iv2       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_idle("rst_vs_valid", 1'b0);
    iv2   = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_vs_valid/still_idle", 128'(ir2), 128'd1);
    run_req("x_d2_after", 1'b0, 5'd2, 64'd99, 128'd495, 1'b0, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/repeat_sum.md
# repeat_sum

Sequential, parametrised calculator for repeated-block ID sums. For one digit-count class D and upper bound n, it returns the sum of every D-digit value x ≤ n whose decimal string is a block repeated either exactly REPS times (exact mode) or any number of times ≥ 2 (any mode). Any mode uses inclusion–exclusion over the distinct prime factors of D. The block sits downstream of the range splitter, which issues one request per digit-count class. Its per-class results feed the part-1/part-2 accumulators. It replaces the fixed-REPS, free-running group counter with a handshaked, multi-term engine.

## Interface
- DATA_WIDTH, 64: width of n_in, blocks, bases.
- SUM_WIDTH, 128: width of result and accumulator.
- MAX_DIGITS, 19: largest legal n_digs_in; must be ≤ 29 (guarantees ≤ 2 distinct primes of D).
- REPS, 2: exact repetition count; REPS = 0 selects any mode.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset == 0 at a rising edge resets the block.
- in_valid  in  1  request present.
- in_ready  out  1  high only in IDLE.
- n_in  in  DATA_WIDTH  inclusive upper bound n.
- n_digs_in  in  5  digit count D.
- out_valid  out  1  result present; held until accepted.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  SUM_WIDTH  result.
- err_out  out  1  qualifies sum_out; set when D = 0 or D > MAX_DIGITS (sum_out = 0).

## Operation
- States: IDLE → SETUP → TERM (0 or more terms) → DONE → IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: latch n and D, clear acc, go to SETUP.
- SETUP (1 cycle): build the term list of (b, sign) pairs, with term count T ≤ 3.
  - Exact mode: if D % REPS == 0 and D ≥ REPS, the list is {(D/REPS, +)}; otherwise the list is empty.
  - Any mode, D with distinct primes q1 < q2: list is (D/q1, +), (D/q2, +), (D/(q1·q2), −), in that order.
  - Any mode, D with a single prime q: list is (D/q, +).
  - Any mode, D = 1: list is empty.
  - Illegal D (0 or > MAX_DIGITS): list is empty; set err.
- TERM: each term takes 4 sub-cycles, P0..P3.
  - P0: base = (10^D − 1)/(10^b − 1).
  - P1: lb = 10^(b−1); ub = min(10^b − 1, n/base).
  - P2: if ub < lb the term is 0. Otherwise S = lb + ub, N = ub − lb + 1.
  - P3: term = base·((S·N) >> 1); acc ← acc ± term.
  - Term ordering guarantees acc never goes negative, so acc is unsigned SUM_WIDTH.
- DONE
  - out_valid = 1; sum_out = acc; err_out = err.
  - sum_out and err_out hold stable while out_ready = 0.
  - On out_ready: go to IDLE.
- Arithmetic rules:
  - Powers of ten come from a constant table, indices 0..MAX_DIGITS.
  - The S·N product is computed at SUM_WIDTH.
  - Divisions are combinational, one per sub-cycle.
- Boundary conditions:
  - n < 10^(D−1): every term has ub < lb, so the result is 0.
  - n ≥ 10^D: ub is clamped to 10^b − 1, giving the full class sum.
  - in_valid while busy is ignored; the request stays pending upstream.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, sum_out = 0, err_out = 0. Internal acc, err and term index are cleared.
- Handshake in cycle 0 → SETUP in cycle 1 → TERM in cycles 2..4T+1 → out_valid rises in cycle 2 + 4T.
  - Latency by term count: T = 0 → 2 cycles, T = 1 → 6, T = 3 → 14.
- Throughput: the next request can be accepted no earlier than the cycle after the out_valid & out_ready handshake.
- Back-to-back operation: the handshake cycle returns the block to IDLE, so in_ready is high in the next cycle.
- Reset low in any state: at that edge, return to IDLE with all outputs at reset values. Any in-flight result is discarded.
- Reset and in_valid in the same cycle: reset wins; the request is not accepted.

## Test plan
- REPS = 2, n = 99, D = 2 → sum_out = 495, err_out = 0, out_valid 6 cycles after the handshake.
- REPS = 2, n = 1234, D = 4 → sum_out = 3333 (1010 + 1111 + 1212).
- REPS = 2, D = 3, n = 999 → sum_out = 0 at 2 cycles. REPS = 0, D = 1 → sum_out = 0 at 2 cycles.
- REPS = 0, n = 999999, D = 6 → sum_out = 539589960 (495044550 + 49545405 − 4999995), latency 14 cycles.
- REPS = 0, D = 0 → err_out = 1, sum_out = 0. REPS = 0, D = 4, n = 999 → sum_out = 0, err_out = 0.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles: out_valid, sum_out and in_ready (= 0) stay stable.
  - Pull reset low during TERM: the next cycle shows IDLE and reset outputs; a fresh request then produces the correct value.
